// File: rtl/fetch_unit_if.sv
// fetch_unit_if: groups the instruction-memory, redirect and decode-side
// signals of the fetch stage.
//   master : fetch_unit side (drives imem_req_o/imem_addr_o, valid_o/pc_o/insn_o)
//   slave  : environment side (memory, branch unit, decode)
// Member names keep the original port names of fetch_unit.
interface fetch_unit_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
);
  logic              imem_req_o;
  logic [AWIDTH-1:0] imem_addr_o;
  logic              imem_gnt_i;
  logic              imem_rvalid_i;
  logic [DWIDTH-1:0] imem_rdata_i;
  logic              redirect_i;
  logic [AWIDTH-1:0] redirect_pc_i;
  logic              valid_o;
  logic              ready_i;
  logic [AWIDTH-1:0] pc_o;
  logic [DWIDTH-1:0] insn_o;

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    input  redirect_i, redirect_pc_i,
    output valid_o, pc_o, insn_o,
    input  ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    output redirect_i, redirect_pc_i,
    input  valid_o, pc_o, insn_o,
    output ready_i
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage upstream of decode.
// Owns the PC, issues in-order word requests (req/gnt, in-order rvalid),
// buffers returned instructions tagged with their PC in a FIFO and presents
// {pc, insn} to decode with valid/ready. A redirect flushes the buffer and
// discards all responses still in flight for the old stream.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - fetch_unit_if.master: imem_* memory port, redirect_*, decode
//          handshake valid_o/ready_i/pc_o/insn_o
module fetch_unit #(
  parameter int                DWIDTH     = 32,
  parameter int                AWIDTH     = 32,
  parameter logic [AWIDTH-1:0] BASEADDR   = AWIDTH'(32'h0100_0000),
  parameter int                FIFO_DEPTH = 4
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef logic [CW-1:0] cnt_t;

  logic [AWIDTH-1:0] fetch_pc;
  logic [AWIDTH-1:0] resp_pc;
  logic [AWIDTH-1:0] pc_mem   [FIFO_DEPTH];
  logic [DWIDTH-1:0] insn_mem [FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  cnt_t              count;
  cnt_t              outstanding;
  cnt_t              drop_cnt;

  logic [CW:0]       in_use;
  logic              req;
  logic              fire;
  logic              push;
  logic              pop;
  logic              empty;
  cnt_t              outstanding_nxt;
  logic [AWIDTH-1:0] redirect_base;

  always_comb begin
    // Buffered plus in-flight entries may never exceed the FIFO, so every
    // response is guaranteed a slot (or a concurrent pop).
    in_use          = {1'b0, count} + {1'b0, outstanding};
    req             = !rst && !bus.redirect_i && (in_use < (CW+1)'(FIFO_DEPTH));
    fire            = req && bus.imem_gnt_i;
    empty           = (count == '0);
    push            = bus.imem_rvalid_i && !bus.redirect_i && (drop_cnt == '0);
    pop             = !empty && bus.ready_i && !bus.redirect_i;
    outstanding_nxt = outstanding + cnt_t'(fire) - cnt_t'(bus.imem_rvalid_i);
    redirect_base   = bus.redirect_pc_i & ~AWIDTH'(3);
  end

  assign bus.imem_req_o  = req;
  assign bus.imem_addr_o = fetch_pc;
  assign bus.valid_o     = !empty;
  assign bus.pc_o        = empty ? '0 : pc_mem[rd_ptr];
  assign bus.insn_o      = empty ? '0 : insn_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= BASEADDR;
      resp_pc     <= BASEADDR;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (bus.redirect_i) begin
        fetch_pc <= redirect_base;
        resp_pc  <= redirect_base;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        // No request can issue in a redirect cycle, so everything still in
        // flight after this edge belongs to the old stream.
        drop_cnt <= outstanding_nxt;
      end else begin
        if (fire) fetch_pc <= fetch_pc + AWIDTH'(4);
        if (push) begin
          resp_pc <= resp_pc + AWIDTH'(4);
          wr_ptr  <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count + cnt_t'(push) - cnt_t'(pop);
        if (bus.imem_rvalid_i && (drop_cnt != '0)) drop_cnt <= drop_cnt - cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      pc_mem[wr_ptr]   <= resp_pc;
      insn_mem[wr_ptr] <= bus.imem_rdata_i;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: a memory model with random grant/latency, a
// reference model of the expected decode stream (epoch-tagged requests; only
// current-epoch responses reach decode) and a scoreboard monitor.
module tb_fetch_unit;
  localparam logic [31:0] BASE  = 32'h0100_0000;
  localparam int          DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_unit_if #(.DWIDTH(32), .AWIDTH(32)) bus ();

  fetch_unit #(
    .DWIDTH    (32),
    .AWIDTH    (32),
    .BASEADDR  (BASE),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int unsigned epoch;
    int unsigned due;
  } pend_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  pend_t       pending[$];
  exp_t        sb[$];
  logic [31:0] fixed_data[$];

  int          vectors = 0;
  int          errors  = 0;
  int unsigned cyc     = 0;
  int unsigned epoch   = 0;
  int          grant_cnt = 0;
  logic [31:0] model_pc = BASE;
  bit          mon_popped = 0;

  // stimulus knobs
  bit          force_rst;
  bit          force_redir = 0;
  logic [31:0] force_redir_pc;
  int          gnt_pct, rdy_pct, rv_pct, redir_permil;
  int unsigned lat_min, lat_max;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Driver: all inputs change 1 time unit after the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      rst = force_rst;
      bus.imem_gnt_i = ($urandom_range(99) < gnt_pct);
      bus.ready_i    = ($urandom_range(99) < rdy_pct);
      if (force_redir) begin
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = force_redir_pc;
        force_redir       = 0;
      end else begin
        bus.redirect_i = !force_rst && ($urandom_range(999) < redir_permil);
        if ($urandom_range(3) == 0) bus.redirect_pc_i = 32'hFFFF_FFF0 | 32'($urandom_range(15));
        else                        bus.redirect_pc_i = $urandom;
      end
      if (!force_rst && pending.size() != 0 && pending[0].due <= cyc &&
          $urandom_range(99) < rv_pct) begin
        bus.imem_rvalid_i = 1'b1;
        bus.imem_rdata_i  = pending[0].data;
      end else begin
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = $urandom;
      end
    end
  end

  // Monitor: checks the decode-side outputs against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      mon_popped = 0;
      chk("valid", 64'(bus.valid_o), 64'(sb.size() != 0));
      if (bus.valid_o && sb.size() != 0) begin
        chk("head_pc",   64'(bus.pc_o),   64'(sb[0].addr));
        chk("head_insn", 64'(bus.insn_o), 64'(sb[0].data));
        if (bus.ready_i && !bus.redirect_i && !rst) begin
          void'(sb.pop_front());
          mon_popped = 1;
        end
      end else if (!bus.valid_o) begin
        chk("empty_out", {bus.pc_o, bus.insn_o}, 64'd0);
      end
    end
  end

  // Reference model: outcome of the upcoming clock edge.
  initial begin
    pend_t       p;
    exp_t        e;
    bit          exp_req;
    int unsigned lat;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        chk("req_in_reset", 64'(bus.imem_req_o), 64'd0);
        pending.delete();
        sb.delete();
        model_pc = BASE;
        epoch++;
      end else begin
        exp_req = !bus.redirect_i &&
                  (sb.size() + int'(mon_popped) + pending.size() < DEPTH);
        chk("req_credit", 64'(bus.imem_req_o), 64'(exp_req));
        if (bus.imem_req_o && bus.imem_gnt_i) begin
          chk("req_addr", 64'(bus.imem_addr_o), 64'(model_pc));
          grant_cnt++;
          lat    = $urandom_range(lat_max, lat_min);
          p.addr = model_pc;
          p.data = (fixed_data.size() != 0) ? fixed_data.pop_front() : $urandom;
          p.epoch = epoch;
          p.due  = cyc + lat;
          pending.push_back(p);
          model_pc = model_pc + 32'd4;
        end
        if (bus.imem_rvalid_i && pending.size() != 0) begin
          p = pending.pop_front();
          if (!bus.redirect_i && p.epoch == epoch) begin
            e.addr = p.addr;
            e.data = p.data;
            sb.push_back(e);
          end
        end
        if (bus.redirect_i) begin
          sb.delete();
          epoch++;
          model_pc = bus.redirect_pc_i & ~32'd3;
        end
      end
    end
  end

  initial begin
    int g0;
    rst = 1'b1;
    bus.imem_gnt_i = 0; bus.imem_rvalid_i = 0; bus.imem_rdata_i = '0;
    bus.redirect_i = 0; bus.redirect_pc_i = '0; bus.ready_i = 0;
    force_rst = 1; gnt_pct = 100; rdy_pct = 100; rv_pct = 100;
    redir_permil = 0; lat_min = 1; lat_max = 1;

    // reset held two cycles, then streaming with known instructions
    wait_cycles(2);
    fixed_data.push_back(32'h0073_0293);
    fixed_data.push_back(32'h4073_02B3);
    fixed_data.push_back(32'h0073_4293);
    force_rst = 0;
    wait_cycles(10);

    // backpressure: exactly DEPTH grants, then one pop allows one more
    force_rst = 1; wait_cycles(1); force_rst = 0;
    rdy_pct = 0;
    g0 = grant_cnt;
    wait_cycles(12);
    chk("bp_grants", 64'(grant_cnt - g0), 64'd4);
    rdy_pct = 100; wait_cycles(1); rdy_pct = 0;
    wait_cycles(10);
    chk("bp_one_more", 64'(grant_cnt - g0), 64'd5);

    // reset with a full FIFO, fetch restarts at BASE
    force_rst = 1; wait_cycles(1); force_rst = 0;
    rdy_pct = 100;
    wait_cycles(6);

    // redirect with two in flight, latency 3
    force_rst = 1; wait_cycles(1); force_rst = 0;
    lat_min = 3; lat_max = 3;
    wait_cycles(2);
    gnt_pct = 0; force_redir = 1; force_redir_pc = 32'h0100_0103;
    wait_cycles(1);
    gnt_pct = 100;
    wait_cycles(12);

    // redirect coincident with rvalid and ready while streaming
    lat_min = 1; lat_max = 1;
    wait_cycles(8);
    force_redir = 1; force_redir_pc = 32'h0200_0002;
    wait_cycles(10);

    // randomized traffic
    gnt_pct = 70; rdy_pct = 60; rv_pct = 70; redir_permil = 40;
    lat_min = 1; lat_max = 4;
    wait_cycles(3000);

    // drain: every granted response must have been delivered or dropped
    redir_permil = 0; gnt_pct = 0; rdy_pct = 100; rv_pct = 100;
    wait_cycles(40);
    chk("drain_pending", 64'(pending.size()), 64'd0);
    chk("drain_sb", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage; sits directly upstream of decode.
- Owns the PC and issues in-order word requests to instruction memory over a req/gnt + rvalid interface.
- Buffers returned instructions, each tagged with its PC, in a small FIFO and presents {pc, insn} to decode with a valid/ready handshake.
- Supports a redirect (branch/jump) that flushes the buffer and discards in-flight responses.

Parameters:
DWIDTH, 32, instruction word width
AWIDTH, 32, address/PC width
BASEADDR, 32'h0100_0000, PC value after reset
FIFO_DEPTH, 4, instruction buffer entries (power of 2, >=2); also the cap on outstanding memory requests

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
imem_req_o  out  1  fetch request valid
imem_addr_o  out  AWIDTH  fetch address (word-aligned)
imem_gnt_i  in  1  memory accepts request this cycle
imem_rvalid_i  in  1  response valid (in order, >=1 cycle after grant)
imem_rdata_i  in  DWIDTH  response instruction
redirect_i  in  1  redirect fetch stream
redirect_pc_i  in  AWIDTH  new PC
valid_o  out  1  instruction available to decode
ready_i  in  1  decode accepts instruction
pc_o  out  AWIDTH  PC of head instruction
insn_o  out  DWIDTH  head instruction

Behaviour:
- Reset is sampled on clk, synchronous. While rst=1 and on the first edge after release:
  - fetch_pc=BASEADDR, resp_pc=BASEADDR.
  - FIFO empty, outstanding=0, drop_cnt=0.
  - valid_o=0, imem_req_o=0, pc_o=0, insn_o=0.
- Reset asserted mid-operation discards everything, including in-flight responses. Responses arriving after reset are the memory's responsibility; the memory is reset by the same rst.
- Credit rule: imem_req_o = !rst && !redirect_i && (count + outstanding < FIFO_DEPTH).
- imem_addr_o = fetch_pc.
- On req&&gnt: fetch_pc += 4 (wraps modulo 2^AWIDTH); outstanding++.
- On imem_rvalid_i: outstanding--.
  - If drop_cnt>0, the response is discarded and drop_cnt--.
  - Otherwise push {resp_pc, imem_rdata_i} and resp_pc += 4.
- Outputs:
  - valid_o = FIFO not empty.
  - pc_o/insn_o = head entry, driven combinationally from FIFO storage; 0 when empty.
  - Pop on valid_o&&ready_i.
- Latency: a response arriving in cycle N is visible on valid_o in cycle N+1; there is no bypass.
- Push and pop in the same cycle are allowed at any occupancy, including full.
- The credit rule guarantees no push while full with no pop.
- Redirect cycle (redirect_i=1):
  - FIFO flushed; any pop that cycle is ignored.
  - fetch_pc and resp_pc <= {redirect_pc_i[AWIDTH-1:2],2'b00}; the low two bits are forced to zero.
  - No request is issued that cycle.
  - drop_cnt <= outstanding - (rvalid?1:0) + (drop_cnt adjustment), i.e. drop_cnt becomes the total number of old-stream responses still in flight after this cycle.
  - An rvalid in the redirect cycle is always discarded.
- Redirect while drop_cnt>0: the counts accumulate correctly; the new drop_cnt equals outstanding after the cycle.
- Back-to-back redirects: the last one wins.
- No state machine beyond the counters. Internal modes:
  - RUN: drop_cnt=0.
  - DRAIN: drop_cnt>0. Requests may still be issued in DRAIN, subject to credit; outstanding includes to-be-dropped responses.
- Widths:
  - outstanding, count, drop_cnt: $clog2(FIFO_DEPTH)+1 bits.
  - The FIFO pointer wraps modulo FIFO_DEPTH.

Test Plan:
1. Reset check: hold rst 2 cycles, release -> valid_o=0, imem_req_o=0 during reset, then imem_req_o=1 with imem_addr_o=0x01000000.
2. Streaming: memory with gnt=1, 1-cycle rvalid; ready_i=1; data 0x00730293, 0x407302B3, 0x00734293 -> decode sees pc 0x01000000/0x01000004/0x01000008 with those insns, one per cycle after a 2-cycle fill.
3. Backpressure: ready_i=0 -> exactly 4 grants, then imem_req_o=0, FIFO full. Set ready_i=1 for one cycle -> one pop, then exactly one new request.
4. Redirect with in-flight: memory latency 3 cycles, 2 outstanding, redirect_i to 0x01000103 -> next request at 0x01000100, both old responses dropped, first valid_o shows pc_o=0x01000100.
5. Redirect coincident with rvalid and ready_i -> that response is dropped, no pop is counted, FIFO empty next cycle, drop_cnt equals the remaining outstanding.
6. Reset mid-stream with a full FIFO -> next cycle valid_o=0, fetch restarts at 0x01000000.
